// File: rtl/ckemon_pkg.sv
// ckemon_pkg: shared types for the clock-enable monitor.
//   state_t : measurement FSM state encoding (IDLE, MEAS, TOUT).
package ckemon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,   // no edge seen since reset
        MEAS = 2'd1,   // counting cycles since the last edge
        TOUT = 2'd2    // no edge for TMAX cycles; counter frozen
    } state_t;

endpackage : ckemon_pkg

// File: rtl/ckesync.sv
// ckesync: SYNC-stage flop synchronizer for a single-bit signal that may be
// asynchronous to clk.
//   clk  in  system clock
//   rst_ in  asynchronous active-low reset; clears every stage
//   d    in  asynchronous input
//   q    out synchronized output (last stage)
module ckesync #(
    parameter int SYNC = 2
) (
    input  logic clk,
    input  logic rst_,
    input  logic d,
    output logic q
);

    logic [SYNC-1:0] ff;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            ff <= '0;
        end else begin
            ff <= {ff[SYNC-2:0], d};
        end
    end

    assign q = ff[SYNC-1];

endmodule : ckesync

// File: rtl/ckemon.sv
// ckemon: clock-enable monitor. Synchronizes a strobe, detects its rising
// edges, measures the edge-to-edge period in clk cycles and offers each
// measurement through a one-entry buffer.
//   clk     in   system clock
//   rst_    in   asynchronous active-low reset
//   strobe  in   monitored signal, may be asynchronous to clk
//   period  out  last measured period (CW bits), meaningful while valid=1
//   valid   out  period holds an unconsumed result
//   ready   in   consumer accepts period on a cycle with valid&&ready
//   timeout out  level: no edge for TMAX cycles
//   overrun out  sticky: a result was dropped because the buffer was full
//
// Handshake: a transfer happens on every rising clk edge where valid and
// ready are both 1. valid is registered and never depends combinationally on
// ready; once raised it stays high with period stable until a transfer.
module ckemon
    import ckemon_pkg::*;
#(
    parameter int unsigned TMAX = 100000000,
    parameter int          SYNC = 2,
    parameter int          CW   = $clog2(TMAX + 1)
) (
    input  logic          clk,
    input  logic          rst_,
    input  logic          strobe,
    output logic [CW-1:0] period,
    output logic          valid,
    input  logic          ready,
    output logic          timeout,
    output logic          overrun
);

    localparam logic [CW-1:0] TMAX_C = CW'(TMAX);
    localparam logic [CW-1:0] ONE_C  = CW'(1);

    logic          sync_out;
    logic          prev;
    logic          rise;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tout_q, tout_d;
    logic          capture;

    logic [CW-1:0] period_q;
    logic          valid_q;
    logic          overrun_q;

    ckesync #(.SYNC(SYNC)) u_sync (
        .clk  (clk),
        .rst_ (rst_),
        .d    (strobe),
        .q    (sync_out)
    );

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            prev <= 1'b0;
        end else begin
            prev <= sync_out;
        end
    end

    // Rising edge of the synchronized strobe, valid for one cycle.
    assign rise = sync_out & ~prev;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tout_q  <= tout_d;
        end
    end

    // cnt holds the number of cycles since the last edge cycle, so a capture
    // on the next edge reads the period directly. The synchronizer delay
    // applies equally to both edges and cancels out.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tout_d  = tout_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = MEAS;
                    cnt_d   = ONE_C;
                end
            end
            MEAS: begin
                // An edge on the same cycle cnt reaches TMAX still reports.
                if (rise) begin
                    capture = 1'b1;
                    cnt_d   = ONE_C;
                end else if (cnt_q == TMAX_C) begin
                    state_d = TOUT;
                    tout_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE_C;
                end
            end
            TOUT: begin
                // The period spanning the timeout is discarded.
                if (rise) begin
                    state_d = MEAS;
                    cnt_d   = ONE_C;
                    tout_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                tout_d  = 1'b0;
            end
        endcase
    end

    // One-entry result buffer. A capture into a full buffer is accepted only
    // if the held entry leaves on the same edge; otherwise it is dropped.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            period_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else if (capture) begin
            if (!valid_q || ready) begin
                period_q <= cnt_q;
                valid_q  <= 1'b1;
            end else begin
                overrun_q <= 1'b1;
            end
        end else if (valid_q && ready) begin
            valid_q <= 1'b0;
        end
    end

    assign period  = period_q;
    assign valid   = valid_q;
    assign timeout = tout_q;
    assign overrun = overrun_q;

endmodule : ckemon

// File: tb/tb_ckemon.sv
module tb_ckemon;

  localparam int unsigned TMAX = 20;
  localparam int          SYNC = 2;
  localparam int          CW   = $clog2(TMAX + 1);

  logic          clk;
  logic          rst_;
  logic          strobe;
  logic [CW-1:0] period;
  logic          valid;
  logic          ready;
  logic          timeout;
  logic          overrun;

  int checks = 0;
  int errors = 0;

  logic [CW-1:0] exp_q[$];

  ckemon #(.TMAX(TMAX), .SYNC(SYNC)) dut (
    .clk     (clk),
    .rst_    (rst_),
    .strobe  (strobe),
    .period  (period),
    .valid   (valid),
    .ready   (ready),
    .timeout (timeout),
    .overrun (overrun)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // scoreboard monitor: one transfer per negedge sample of valid&&ready
  always @(negedge clk) begin
    if (rst_ && valid && ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: actual period=%0d required=no result", period);
      end else begin
        logic [CW-1:0] e;
        e = exp_q.pop_front();
        if (period !== e) begin
          errors++;
          $display("FAIL period: actual=%0d required=%0d", period, e);
        end
      end
    end
  end

  // driver tasks (inputs change 1 time unit after the rising edge)
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_   = 1'b0;
    strobe = 1'b0;
    repeat (2) step();
    rst_ = 1'b1;
    step();
  endtask

  // one-cycle strobe; the next pulse starts gap cycles after this one
  task automatic pulse(input int gap);
    strobe = 1'b1;
    step();
    strobe = 1'b0;
    repeat (gap - 1) step();
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      step();
      n++;
    end
    check("drain_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    rst_   = 1'b0;
    strobe = 1'b0;
    ready  = 1'b1;
    #3;
    check("rst_period", period, 0);
    check("rst_valid", valid, 0);
    check("rst_timeout", timeout, 0);
    check("rst_overrun", overrun, 0);
    do_reset();

    // steady period 5, ready=1
    pulse(5);
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(CW'(5));
      pulse(5);
    end
    wait_drain();
    check("p5_timeout", timeout, 0);
    check("p5_overrun", overrun, 0);

    // single pulse then silence: timeout 21 cycles after the edge cycle
    do_reset();
    strobe = 1'b1;
    step();
    strobe = 1'b0;
    repeat (21) step();
    check("tout_early", timeout, 0);
    step();
    check("tout_rise", timeout, 1);
    pulse(7);
    check("tout_clear", timeout, 0);
    exp_q.push_back(CW'(7));
    pulse(7);
    wait_drain();

    // ready=0, strobes every 6: hold first, drop second
    do_reset();
    ready = 1'b0;
    pulse(6);
    exp_q.push_back(CW'(6));
    pulse(6);
    strobe = 1'b1;
    step();
    strobe = 1'b0;
    repeat (3) step();
    check("ovr_set", overrun, 1);
    check("ovr_valid", valid, 1);
    check("ovr_period_held", period, 6);
    ready = 1'b1;
    step();
    ready = 1'b0;
    check("ovr_valid_drop", valid, 0);
    step();
    exp_q.push_back(CW'(6));
    pulse(6);
    check("ovr_next_valid", valid, 1);
    ready = 1'b1;
    wait_drain();
    step();
    check("ovr_sticky", overrun, 1);

    // capture coinciding with a transfer: valid stays, period updates
    do_reset();
    ready = 1'b0;
    pulse(4);
    exp_q.push_back(CW'(4));
    pulse(3);
    exp_q.push_back(CW'(3));
    strobe = 1'b1;
    step();
    strobe = 1'b0;
    step();
    ready = 1'b1;
    step();
    check("coin_valid", valid, 1);
    check("coin_period", period, 3);
    check("coin_overrun", overrun, 0);
    wait_drain();

    // boundary periods: TMAX itself, and the minimum of 2
    do_reset();
    pulse(20);
    exp_q.push_back(CW'(20));
    pulse(2);
    exp_q.push_back(CW'(2));
    pulse(2);
    exp_q.push_back(CW'(2));
    pulse(5);
    wait_drain();
    check("bnd_timeout", timeout, 0);
    check("bnd_overrun", overrun, 0);

    // strobe tied high: one edge, no result, then timeout
    do_reset();
    strobe = 1'b1;
    repeat (22) step();
    check("high_tout_early", timeout, 0);
    step();
    check("high_tout_rise", timeout, 1);
    repeat (10) step();
    check("high_tout_level", timeout, 1);
    strobe = 1'b0;
    step();

    // asynchronous reset in the middle of a measurement
    do_reset();
    ready = 1'b0;
    pulse(5);
    pulse(5);
    pulse(5);
    strobe = 1'b1;
    step();
    strobe = 1'b0;
    step();
    check("pre_rst_valid", valid, 1);
    check("pre_rst_overrun", overrun, 1);
    #2;
    rst_ = 1'b0;
    #1;
    check("arst_period", period, 0);
    check("arst_valid", valid, 0);
    check("arst_timeout", timeout, 0);
    check("arst_overrun", overrun, 0);
    #3;
    rst_ = 1'b1;
    step();
    ready = 1'b1;
    pulse(8);
    check("post_rst_first", valid, 0);
    exp_q.push_back(CW'(8));
    pulse(8);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_ckemon
